cipher: RTL and testbench
=========================

CIPHER -- requirements
Module: cipher

Interface
- REQ-001 SHALL use constant BLK_S, default 128: block width in bits.
- REQ-002 SHALL use constant KEY_S, default 128: round-key width in bits.
- REQ-003 SHALL use constant Nr, default 10: number of AES rounds.
- REQ-004 SHALL use constant Nk, default 4: round_no width in bits.
- REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
- REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
- REQ-007 SHALL have port en, input, 1: one-cycle start pulse; plaintext is valid in the same cycle.
- REQ-008 SHALL have port plaintext, input, BLK_S: block to encrypt; byte i sits at bits [8i+7:8i], and byte 0 is FIPS-197 state byte 0.
- REQ-009 SHALL have port round_key, input, KEY_S: key for the round requested on round_no; valid one cycle after the request.
- REQ-010 SHALL have port ciphertext, output, BLK_S: registered state; final result when en_o=1.
- REQ-011 SHALL have port round_no, output, Nk: round-key index requested from the external key schedule.
- REQ-012 SHALL have port busy, output, 1: high from the cycle after an accepted en until the cycle en_o is high, inclusive.
- REQ-013 SHALL have port en_o, output, 1: one-cycle done pulse.

Function
- REQ-014 SHALL implement states IDLE, KEY_WAIT and ROUND.
- REQ-015 SHALL, in IDLE with en=1, capture plaintext into an internal block register, set round_no=0 and go to KEY_WAIT at the next edge.
- REQ-016 SHALL, in KEY_WAIT, increment round_no to 1 and go to ROUND at the next edge.
- REQ-017 SHALL, in ROUND, apply one round per cycle using round_key, which is the key for the round index requested on the previous cycle.
- REQ-018 SHALL make the round update ciphertext = captured ^ round_key for round 0.
- REQ-019 SHALL make the round update ciphertext = MixColumns(ShiftRows(SubBytes(ciphertext))) ^ round_key for rounds 1..Nr-1.
- REQ-020 SHALL make the round update ciphertext = ShiftRows(SubBytes(ciphertext)) ^ round_key for round Nr, with no MixColumns.
- REQ-021 SHALL increment round_no each ROUND cycle while the requested index is below Nr, then hold it at all-ones (4'hF), the idle value.
- REQ-022 SHALL register en_o=1 on the same edge that writes round Nr, go to IDLE on that edge, and hold en_o low on all other cycles.
- REQ-023 SHALL give a latency of 12 cycles from en sampled at edge T to ciphertext valid with en_o=1 after edge T+12.
- REQ-024 SHALL hold ciphertext stable after completion until the next accepted en produces its round-0 write.
- REQ-025 SHALL ignore en while busy=1; the captured block and the round sequence are unaffected.
- REQ-026 SHALL accept en in the cycle where en_o=1, because the state is already IDLE; the back-to-back throughput is one block per 12 cycles.
- REQ-027 SHALL implement SubBytes as the FIPS-197 forward S-box as a combinational table.
- REQ-028 SHALL implement ShiftRows so that row r rotates left by r, with column-major byte order (byte = 4*col + row).
- REQ-029 SHALL implement MixColumns with the matrix {02,03,01,01} in circulant form, using GF(2^8) with polynomial 0x11B.
- REQ-030 SHALL give all arithmetic fixed widths; the round counter never wraps past Nr.

Reset
- REQ-031 SHALL, with reset=1 at an edge, force state=IDLE, round_no=4'hF, busy=0, en_o=0 and ciphertext=0.
- REQ-032 SHALL give reset priority over en and over round progression.
- REQ-033 SHALL, on reset mid-operation, abort the operation with no en_o pulse; the next en after reset starts cleanly from round 0.

Verification
- REQ-034 SHALL cover: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with en_o high after exactly 12 edges.
- REQ-035 SHALL cover: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32.
- REQ-036 SHALL cover: round_no trace after en -> 0,1,2,...,10, then F; exactly one en_o pulse.
- REQ-037 SHALL cover: second en pulsed 5 cycles after the first, with a different plaintext -> ignored; the output equals the first vector's result.
- REQ-038 SHALL cover: reset at round 6 -> no en_o, round_no=F and ciphertext=0 next cycle; a following en of vector 1 -> correct result after 12 edges.
- REQ-039 SHALL cover: en asserted in the en_o cycle with vector 2 -> vector 1 result is seen at that en_o, then vector 2 result 12 edges later.

Source files
------------

// File: rtl/cipher.sv
// Iterative AES-128 encryption core: one round per cycle, round keys fetched
// from an external key schedule one cycle after each round_no request.
module cipher_mix_col (
    input  logic [3:0][7:0] col,
    output logic [3:0][7:0] mixed
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        mixed[0] = xt(col[0]) ^ xt(col[1]) ^ col[1] ^ col[2] ^ col[3];
        mixed[1] = col[0] ^ xt(col[1]) ^ xt(col[2]) ^ col[2] ^ col[3];
        mixed[2] = col[0] ^ col[1] ^ xt(col[2]) ^ xt(col[3]) ^ col[3];
        mixed[3] = xt(col[0]) ^ col[0] ^ col[1] ^ col[2] ^ xt(col[3]);
    end
endmodule

module cipher #(
    parameter int BLK_S = 128,
    parameter int KEY_S = 128,
    parameter int Nr    = 10,
    parameter int Nk    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [BLK_S-1:0] plaintext,
    input  logic [KEY_S-1:0] round_key,
    output logic [BLK_S-1:0] ciphertext,
    output logic [Nk-1:0]    round_no,
    output logic             busy,
    output logic             en_o
);
    localparam int NB = BLK_S / 8;
    localparam int NC = NB / 4;
    localparam logic [Nk-1:0] LAST_RND = Nk'(Nr);

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    typedef enum logic [1:0] {IDLE, KEY_WAIT, ROUND} state_t;

    state_t             state_q, state_d;
    logic [BLK_S-1:0]   blk_q, blk_d;
    logic [BLK_S-1:0]   ct_q, ct_d;
    logic [Nk-1:0]      rn_q, rn_d;
    logic [Nk-1:0]      rnd_q, rnd_d;     // round being applied this cycle
    logic               en_o_q, en_o_d;

    logic [NB-1:0][7:0] sb, sr, mx;

    genvar gi, gc, gr;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_sub
            assign sb[gi] = SBOX[ct_q[8*gi +: 8]];
        end
        for (gc = 0; gc < NC; gc++) begin : g_col
            for (gr = 0; gr < 4; gr++) begin : g_row
                assign sr[4*gc+gr] = sb[4*((gc+gr)%NC)+gr];
            end
            cipher_mix_col u_mix (
                .col   (sr[4*gc +: 4]),
                .mixed (mx[4*gc +: 4])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        ct_d    = ct_q;
        rn_d    = rn_q;
        rnd_d   = rnd_q;
        en_o_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    blk_d   = plaintext;
                    rn_d    = '0;
                    state_d = KEY_WAIT;
                end
            end
            KEY_WAIT: begin
                rn_d    = Nk'(1);
                rnd_d   = '0;
                state_d = ROUND;
            end
            ROUND: begin
                if (rnd_q == '0)
                    ct_d = blk_q ^ round_key;
                else if (rnd_q == LAST_RND)
                    ct_d = sr ^ round_key;
                else
                    ct_d = mx ^ round_key;
                rn_d = (rn_q < LAST_RND) ? rn_q + Nk'(1) : '1;
                if (rnd_q == LAST_RND) begin
                    en_o_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    rnd_d = rnd_q + Nk'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            blk_q   <= '0;
            ct_q    <= '0;
            rn_q    <= '1;
            rnd_q   <= '0;
            en_o_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            ct_q    <= ct_d;
            rn_q    <= rn_d;
            rnd_q   <= rnd_d;
            en_o_q  <= en_o_d;
        end
    end

    assign ciphertext = ct_q;
    assign round_no   = rn_q;
    assign en_o       = en_o_q;
    assign busy       = (state_q != IDLE) || en_o_q;
endmodule

// File: tb/tb_cipher.sv
// Bench for cipher: FIPS-197 vectors plus random blocks against a byte-level
// AES model with its own GF(2^8)-derived S-box and key expansion.
module tb_cipher;
    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [127:0] plaintext;
    logic [127:0] round_key;
    logic [127:0] ciphertext;
    logic [3:0]   round_no;
    logic         busy;
    logic         en_o;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_tab [11];
    logic [3:0]   req;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    cipher dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .plaintext  (plaintext),
        .round_key  (round_key),
        .ciphertext (ciphertext),
        .round_no   (round_no),
        .busy       (busy),
        .en_o       (en_o)
    );

    always #5 clk = ~clk;

    // External key schedule: key for the index seen this cycle appears next cycle.
    initial begin
        round_key = '0;
        forever begin
            @(negedge clk);
            req = round_no;
            @(posedge clk);
            #1 round_key = (req <= 4'd10) ? rk_tab[req] : '0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS hex string (byte 0 leftmost) to port layout (byte 0 in bits 7:0).
    function automatic logic [127:0] to_port(input logic [127:0] h);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = h[127-8*i -: 8];
        return o;
    endfunction

    task automatic build_keys(input logic [127:0] key);
        logic [7:0] w [44][4];
        logic [7:0] tmp [4];
        logic [7:0] t0;
        logic [7:0] rcon = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                t0 = tmp[0];
                tmp[0] = sbox_t[tmp[1]] ^ rcon;
                tmp[1] = sbox_t[tmp[2]];
                tmp[2] = sbox_t[tmp[3]];
                tmp[3] = sbox_t[t0];
                rcon = gmul(rcon, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) rk_tab[r][8*(4*c+j) +: 8] = w[4*r+c][j];
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk_tab[0][8*i +: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[4*c+rr] = t[4*((c+rr)%4)+rr];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            for (int i = 0; i < 16; i++) s[i] ^= rk_tab[r][8*i +: 8];
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
        return o;
    endfunction

    // Pulse en for one cycle; returns at the negedge right after the accepting edge.
    task automatic launch(input logic [127:0] pt);
        @(negedge clk);
        en = 1'b1;
        plaintext = pt;
        @(negedge clk);
        en = 1'b0;
        plaintext = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Counts edges until en_o; optionally pulses a stray en at edge offset junk_at+1.
    task automatic wait_done(input int junk_at, output int lat);
        lat = 0;
        while (!en_o && lat < 30) begin
            if (lat == junk_at) begin
                en = 1'b1;
                plaintext = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                en = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        en = 1'b0;
    endtask

    initial begin
        int lat;
        int pulses;
        logic [127:0] key, pt, exp_ct, held;

        reset = 1'b1;
        en = 1'b0;
        plaintext = '0;
        build_sbox();
        build_keys(to_port(K1));
        repeat (3) @(negedge clk);
        chk("rst_ct", ciphertext, '0);
        chk("rst_round_no", round_no, 4'hF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_en_o", en_o, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Vector 1 with cycle-by-cycle trace
        launch(to_port(P1));
        for (int j = 0; j <= 12; j++) begin
            chk($sformatf("trace_rn_%0d", j), round_no, (j <= 10) ? 4'(j) : 4'hF);
            chk($sformatf("trace_busy_%0d", j), busy, 1'b1);
            chk($sformatf("trace_en_o_%0d", j), en_o, (j == 12));
            if (j < 12) @(negedge clk);
        end
        chk("v1_ct", ciphertext, to_port(C1));
        held = ciphertext;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (en_o) pulses++;
        end
        chk("v1_extra_pulses", pulses, 0);
        chk("v1_idle_busy", busy, 1'b0);
        chk("v1_idle_rn", round_no, 4'hF);
        chk("v1_hold", ciphertext, held);

        // Vector 2
        build_keys(to_port(K2));
        launch(to_port(P2));
        wait_done(-1, lat);
        chk("v2_lat", lat, 12);
        chk("v2_ct", ciphertext, to_port(C2));

        // Stray en five cycles after start must be ignored
        build_keys(to_port(K1));
        launch(to_port(P1));
        wait_done(4, lat);
        chk("ign_lat", lat, 12);
        chk("ign_ct", ciphertext, to_port(C1));

        // Reset during round 6 aborts the block
        launch(to_port(P2));
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_en_o", en_o, 1'b0);
        chk("abort_rn", round_no, 4'hF);
        chk("abort_ct", ciphertext, '0);
        chk("abort_busy", busy, 1'b0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (en_o) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        launch(to_port(P1));
        wait_done(-1, lat);
        chk("post_abort_lat", lat, 12);
        chk("post_abort_ct", ciphertext, to_port(C1));

        // Back-to-back: new en in the en_o cycle
        launch(to_port(P1));
        wait_done(-1, lat);
        chk("b2b_first_lat", lat, 12);
        chk("b2b_first_ct", ciphertext, to_port(C1));
        en = 1'b1;
        plaintext = to_port(P2);
        build_keys(to_port(K2));
        @(negedge clk);
        en = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        wait_done(-1, lat);
        chk("b2b_second_lat", lat, 12);
        chk("b2b_second_ct", ciphertext, to_port(C2));

        // Random blocks and keys against the model
        for (int n = 0; n < 8; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            build_keys(key);
            exp_ct = model_enc(pt);
            launch(pt);
            wait_done((n % 2 == 1) ? int'($urandom_range(0, 10)) : -1, lat);
            chk($sformatf("rand%0d_lat", n), lat, 12);
            chk($sformatf("rand%0d_ct", n), ciphertext, exp_ct);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
